// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the program counter and issues
//               one word read at a time to instruction memory. Fetched
//               {pc, instr} pairs are buffered in a small circular FIFO and
//               handed downstream with a valid/ready handshake. A redirect
//               loads a new PC and flushes every buffered and in-flight fetch.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               imem_req, imem_addr      - single-cycle read request and address
//               imem_rvalid, imem_rdata  - read response from instruction memory
//               redirect_valid/_pc       - new fetch target, flushes the stage
//               out_valid, out_ready     - downstream handshake on FIFO head
//               out_pc, out_instr        - head entry contents
//               out_pc_plus4             - out_pc + 4 (mod 2^32)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    // IDLE: nothing outstanding; WAIT: response will be kept;
    // DROP: response belongs to a flushed fetch and will be discarded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_pc;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];

    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;

    // The low bits of a redirect target are forced to zero (word alignment).
    logic               w_unused;
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // Only one request may be outstanding, and only when the FIFO is
    // guaranteed to have room for its response.
    assign w_req      = (r_state == ST_IDLE) && (r_count < c_depth) && !redirect_valid && !rst;
    assign w_nonempty = (r_count != '0);
    // A redirect flushes the FIFO, so a coincident pop is suppressed.
    assign w_pop      = w_nonempty && out_ready && !redirect_valid;

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign out_valid    = w_nonempty && !rst;
    assign out_pc       = r_mem_pc[r_head];
    assign out_instr    = r_mem_instr[r_head];
    assign out_pc_plus4 = r_mem_pc[r_head] + 32'd4;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A response arriving here is a protocol violation: ignored.
                if (w_req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_push      = 1'b1;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            // Storage is cleared so the data outputs are never X.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_req) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_push) begin
                r_mem_pc[r_tail]    <= r_req_pc;
                r_mem_instr[r_tail] <= imem_rdata;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
